// File: rtl/fetch_ctrl.sv
// fetch_ctrl: program-counter / fetch sequencer for the single-cycle core.
// Runs the start/done handshake with the bench, picks the next PC
// (sequential, absolute jump, relative jump, taken branch), stops on the
// all-ones halt word and counts the cycles spent in RUN.

module fetch_ctrl_chk #(
  parameter int D = 10
) (
  input logic         clk,
  input logic         reset,
  input logic         start,
  input logic         run,
  input logic         done,
  input logic [D-1:0] prog_ctr
);

  // run and done come from distinct states and can never be high together
  a_run_done_excl: assert property (@(posedge clk) disable iff (reset)
    !(run && done));

  // without a new start request a halted program stays halted at the same PC
  a_halt_frozen: assert property (@(posedge clk) disable iff (reset)
    (done && !start) |=> (done && $stable(prog_ctr)));

endmodule

module fetch_ctrl #(
  parameter int D    = 10,
  parameter int W    = 9,
  parameter int OFFW = 6,
  parameter int CW   = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [W-1:0]    mach_code,
  input  logic            absj,
  input  logic            relj,
  input  logic            branch,
  input  logic            flag_q,
  input  logic [D-1:0]    target,
  input  logic [OFFW-1:0] rel_off,
  output logic [D-1:0]    prog_ctr,
  output logic            run,
  output logic            done,
  output logic [CW-1:0]   cycle_cnt
);

  // Sequencer states; kept as plain constants so older tools can read them.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_HALT = 2'd3;

  localparam logic [D-1:0]  PC_ZERO  = {D{1'b0}};
  localparam logic [D-1:0]  PC_ONE   = {{(D-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [W-1:0]  HALT_WORD = {W{1'b1}};

  // Sign-extend the relative offset to PC width so the add wraps mod 2^D.
  function automatic logic [D-1:0] sext_off(input logic [OFFW-1:0] off);
    sext_off = {{(D-OFFW){off[OFFW-1]}}, off};
  endfunction

  // Saturating increment: the counter sticks at all-ones rather than wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] val);
    if (val == CNT_MAX) begin
      sat_inc = val;
    end else begin
      sat_inc = val + CNT_ONE;
    end
  endfunction

  logic [1:0]    state_q, state_d;
  logic [D-1:0]  pc_q, pc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_q, run_d;
  logic          done_q, done_d;
  logic          is_halt_s;
  logic [D-1:0]  pc_rel_s;
  logic [D-1:0]  pc_seq_s;

  // Datapath helpers: halt-word decode and the two candidate PC sums.
  always_comb begin
    is_halt_s = (mach_code == HALT_WORD);
    pc_rel_s  = pc_q + sext_off(rel_off);
    pc_seq_s  = pc_q + PC_ONE;
  end

  // Next-state, next-PC and cycle-counter selection.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        pc_d = PC_ZERO;
        if (start) begin
          state_d = ST_ARM;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARM: begin
        // PC and counter are pinned at zero so the first RUN cycle fetches 0.
        pc_d  = PC_ZERO;
        cnt_d = CNT_ZERO;
        if (start) begin
          state_d = ST_ARM;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // start is deliberately not looked at here: no restart mid-program.
        cnt_d = sat_inc(cnt_q);
        if (is_halt_s) begin
          // Halt wins over any redirect; PC stays on the halt address.
          state_d = ST_HALT;
          pc_d    = pc_q;
        end else if (absj) begin
          state_d = ST_RUN;
          pc_d    = target;
        end else if (relj) begin
          state_d = ST_RUN;
          pc_d    = pc_rel_s;
        end else if (branch && flag_q) begin
          state_d = ST_RUN;
          pc_d    = pc_rel_s;
        end else begin
          state_d = ST_RUN;
          pc_d    = pc_seq_s;
        end
      end
      ST_HALT: begin
        if (start) begin
          // Re-arm: PC and counter clear on the same edge that drops done.
          state_d = ST_ARM;
          pc_d    = PC_ZERO;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = ST_HALT;
          pc_d    = pc_q;
          cnt_d   = cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        pc_d    = PC_ZERO;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // run/done are decoded from the next state so they can be registered.
  always_comb begin
    run_d  = (state_d == ST_RUN);
    done_d = (state_d == ST_HALT);
  end

  // State, PC, counter and status flops with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= PC_ZERO;
      cnt_q   <= CNT_ZERO;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      done_q  <= done_d;
    end
  end

  assign prog_ctr  = pc_q;
  assign run       = run_q;
  assign done      = done_q;
  assign cycle_cnt = cnt_q;

  fetch_ctrl_chk #(.D(D)) u_chk (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .run      (run_q),
    .done     (done_q),
    .prog_ctr (pc_q)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: handshake, PC selection priority, wrap,
// halt/freeze, restart from HALT and asynchronous reset mid-program.

module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [8:0]  mach_code;
  logic        absj, relj, branch, flag_q;
  logic [9:0]  target;
  logic [5:0]  rel_off;
  logic [9:0]  prog_ctr;
  logic        run, done;
  logic [15:0] cycle_cnt;

  logic        halt_en;
  logic [9:0]  halt_addr;
  int          total = 0;
  int          bad   = 0;
  logic [27:0] got_v, exp_v;

  // Tiny instruction ROM: halt word at halt_addr when enabled, filler elsewhere.
  assign mach_code = (halt_en && (prog_ctr == halt_addr)) ? 9'h1FF : 9'h0A5;
  assign got_v     = {prog_ctr, run, done, cycle_cnt};

  fetch_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mach_code (mach_code),
    .absj      (absj),
    .relj      (relj),
    .branch    (branch),
    .flag_q    (flag_q),
    .target    (target),
    .rel_off   (rel_off),
    .prog_ctr  (prog_ctr),
    .run       (run),
    .done      (done),
    .cycle_cnt (cycle_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [27:0] mk(input logic [9:0] pc, input logic r,
                                     input logic d, input logic [15:0] c);
    mk = {pc, r, d, c};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    absj = 1'b0; relj = 1'b0; branch = 1'b0; flag_q = 1'b0;
    target = 10'h000; rel_off = 6'h00;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; halt_en = 1'b0; halt_addr = 10'h000;
    clear_ctl();
    #1 reset = 1'b1;
    #1;
    exp_v = mk(10'h000, 1'b0, 1'b0, 16'd0);
    total++;
    if (got_v !== exp_v) begin bad++; $display("FAIL reset_state got=%h want=%h", got_v, exp_v); end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_sequential();
    start = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      exp_v = mk(10'h000, 1'b0, 1'b0, 16'd0);
      total++;
      if (got_v !== exp_v) begin bad++; $display("FAIL arm_hold%0d got=%h want=%h", i, got_v, exp_v); end
    end
    start = 1'b0;
    tick();
    exp_v = mk(10'h000, 1'b1, 1'b0, 16'd0);
    total++;
    if (got_v !== exp_v) begin bad++; $display("FAIL run_entry got=%h want=%h", got_v, exp_v); end
    for (int i = 1; i <= 4; i++) begin
      start = (i == 2) ? 1'b1 : 1'b0;
      tick();
      exp_v = mk(10'(i), 1'b1, 1'b0, 16'(i));
      total++;
      if (got_v !== exp_v) begin bad++; $display("FAIL seq_pc%0d got=%h want=%h", i, got_v, exp_v); end
    end
    start = 1'b0;
  endtask

  task automatic test_abs_priority();
    absj = 1'b1; relj = 1'b1; branch = 1'b1; flag_q = 1'b1;
    target = 10'h155; rel_off = 6'h3D;
    tick();
    exp_v = mk(10'h155, 1'b1, 1'b0, 16'd5);
    total++;
    if (got_v !== exp_v) begin bad++; $display("FAIL abs_priority got=%h want=%h", got_v, exp_v); end
    clear_ctl();
  endtask

  task automatic test_branch();
    absj = 1'b1; target = 10'd10;
    tick();
    clear_ctl();
    branch = 1'b1; rel_off = 6'h3D; flag_q = 1'b0;
    tick();
    exp_v = mk(10'd11, 1'b1, 1'b0, 16'd7);
    total++;
    if (got_v !== exp_v) begin bad++; $display("FAIL branch_not_taken got=%h want=%h", got_v, exp_v); end
    clear_ctl();
    absj = 1'b1; target = 10'd10;
    tick();
    clear_ctl();
    branch = 1'b1; rel_off = 6'h3D; flag_q = 1'b1;
    tick();
    exp_v = mk(10'd7, 1'b1, 1'b0, 16'd9);
    total++;
    if (got_v !== exp_v) begin bad++; $display("FAIL branch_taken got=%h want=%h", got_v, exp_v); end
    clear_ctl();
  endtask

  task automatic test_wrap();
    absj = 1'b1; target = 10'h000;
    tick();
    clear_ctl();
    relj = 1'b1; rel_off = 6'h3F;
    tick();
    exp_v = mk(10'h3FF, 1'b1, 1'b0, 16'd11);
    total++;
    if (got_v !== exp_v) begin bad++; $display("FAIL wrap_neg got=%h want=%h", got_v, exp_v); end
    clear_ctl();
    tick();
    exp_v = mk(10'h000, 1'b1, 1'b0, 16'd12);
    total++;
    if (got_v !== exp_v) begin bad++; $display("FAIL wrap_pos got=%h want=%h", got_v, exp_v); end
    relj = 1'b1; rel_off = 6'h1F;
    tick();
    exp_v = mk(10'd31, 1'b1, 1'b0, 16'd13);
    total++;
    if (got_v !== exp_v) begin bad++; $display("FAIL rel_plus31 got=%h want=%h", got_v, exp_v); end
    clear_ctl();
  endtask

  task automatic test_halt();
    reset = 1'b1;
    #1 reset = 1'b0;
    halt_en = 1'b1; halt_addr = 10'd20;
    start = 1'b1; absj = 1'b1; target = 10'h3FF;
    tick();
    exp_v = mk(10'h000, 1'b0, 1'b0, 16'd0);
    total++;
    if (got_v !== exp_v) begin bad++; $display("FAIL jump_ignored_arm got=%h want=%h", got_v, exp_v); end
    clear_ctl();
    start = 1'b0;
    tick();
    for (int i = 1; i <= 20; i++) begin
      tick();
      exp_v = mk(10'(i), 1'b1, 1'b0, 16'(i));
      total++;
      if (got_v !== exp_v) begin bad++; $display("FAIL straight_pc%0d got=%h want=%h", i, got_v, exp_v); end
    end
    absj = 1'b1; target = 10'h2AA;
    tick();
    exp_v = mk(10'd20, 1'b0, 1'b1, 16'd21);
    total++;
    if (got_v !== exp_v) begin bad++; $display("FAIL halt_detect got=%h want=%h", got_v, exp_v); end
    for (int i = 0; i < 10; i++) begin
      relj = i[0];
      tick();
      total++;
      if (got_v !== exp_v) begin bad++; $display("FAIL halt_frozen%0d got=%h want=%h", i, got_v, exp_v); end
    end
    clear_ctl();
  endtask

  task automatic test_restart();
    start = 1'b1;
    tick();
    exp_v = mk(10'h000, 1'b0, 1'b0, 16'd0);
    total++;
    if (got_v !== exp_v) begin bad++; $display("FAIL restart_arm got=%h want=%h", got_v, exp_v); end
    start = 1'b0;
    tick();
    exp_v = mk(10'h000, 1'b1, 1'b0, 16'd0);
    total++;
    if (got_v !== exp_v) begin bad++; $display("FAIL restart_run got=%h want=%h", got_v, exp_v); end
    tick();
    exp_v = mk(10'h001, 1'b1, 1'b0, 16'd1);
    total++;
    if (got_v !== exp_v) begin bad++; $display("FAIL restart_pc1 got=%h want=%h", got_v, exp_v); end
  endtask

  task automatic test_back_to_back();
    halt_addr = 10'd2;
    tick();
    tick();
    exp_v = mk(10'd2, 1'b0, 1'b1, 16'd3);
    total++;
    if (got_v !== exp_v) begin bad++; $display("FAIL b2b_halt got=%h want=%h", got_v, exp_v); end
    halt_en = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    exp_v = mk(10'h000, 1'b1, 1'b0, 16'd0);
    total++;
    if (got_v !== exp_v) begin bad++; $display("FAIL b2b_rerun got=%h want=%h", got_v, exp_v); end
  endtask

  task automatic test_reset_midrun();
    for (int i = 0; i < 37; i++) tick();
    exp_v = mk(10'd37, 1'b1, 1'b0, 16'd37);
    total++;
    if (got_v !== exp_v) begin bad++; $display("FAIL reach_pc37 got=%h want=%h", got_v, exp_v); end
    absj = 1'b1; target = 10'h123;
    #2 reset = 1'b1;
    #1;
    exp_v = mk(10'h000, 1'b0, 1'b0, 16'd0);
    total++;
    if (got_v !== exp_v) begin bad++; $display("FAIL async_reset got=%h want=%h", got_v, exp_v); end
    #1 reset = 1'b0;
    clear_ctl();
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (got_v !== exp_v) begin bad++; $display("FAIL idle_hold%0d got=%h want=%h", i, got_v, exp_v); end
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    exp_v = mk(10'h000, 1'b1, 1'b0, 16'd0);
    total++;
    if (got_v !== exp_v) begin bad++; $display("FAIL post_reset_run got=%h want=%h", got_v, exp_v); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_abs_priority();
    test_branch();
    test_wrap();
    test_halt();
    test_restart();
    test_back_to_back();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
